// File: rtl/pu_or1k_wb_sram_slave_pkg.sv
// Shared definitions for the OR1K Wishbone SRAM responder.
//   CTI_* / BTE_*    : Wishbone B3 cycle-type and burst-type encodings
//   wb_state_t       : responder FSM states
//   next_burst_adr() : byte address of the next beat of an incrementing burst
package pu_or1k_wb_sram_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {IDLE, BURST} wb_state_t;

  // Wrapping bursts only let the low 2/3/4 bits of the word index roll over;
  // everything above is held. Linear carries through the whole address.
  function automatic logic [31:0] next_burst_adr(input logic [31:0] adr,
                                                 input logic [1:0]  bte);
    logic [31:0] inc;
    logic [31:0] mask;
    inc = adr + 32'd4;
    case (bte)
      BTE_WRAP4:  mask = 32'h0000_000C;
      BTE_WRAP8:  mask = 32'h0000_001C;
      BTE_WRAP16: mask = 32'h0000_003C;
      BTE_LINEAR: mask = '1;
      default:    mask = '1;
    endcase
    return ((inc & mask) | (adr & ~mask)) & ~32'h3;
  endfunction

endpackage

// File: rtl/pu_or1k_wb_sram_slave_if.sv
// Wishbone B3 bus bundle between an OR1K master (iwbm/dwbm) and the SRAM responder.
//   adr/dat_wr/sel/we/cyc/stb/cti/bte : master -> slave
//   dat_rd/ack/err/rty                : slave -> master
interface pu_or1k_wb_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_wr;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_rd;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (output adr, dat_wr, sel, we, cyc, stb, cti, bte,
                  input  dat_rd, ack, err, rty);
  modport slave  (input  adr, dat_wr, sel, we, cyc, stb, cti, bte,
                  output dat_rd, ack, err, rty);
endinterface

// File: rtl/pu_or1k_wb_sram_slave_bank.sv
// Single-port byte-enabled synchronous RAM, 1-cycle read latency. Contents are not reset.
//   clk_i   : clock
//   en_i    : access enable (write when we_i, else read)
//   we_i    : write enable
//   be_i    : byte enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access
module pu_or1k_wb_sram_slave_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [DATA_WIDTH/8-1:0]    be_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/pu_or1k_wb_sram_slave.sv
// Wishbone B3 SRAM responder for the OR1K iwbm/dwbm masters: classic cycles with one
// wait state, registered-feedback incrementing bursts (linear, wrap4/8/16) at one beat
// per clock. Accesses outside [BASE_ADDR, BASE_ADDR+DEPTH*4) terminate with err.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   wb     : Wishbone slave port (pu_or1k_wb_sram_slave_if.slave)
module pu_or1k_wb_sram_slave
  import pu_or1k_wb_sram_slave_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  pu_or1k_wb_sram_slave_if.slave  wb
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(DEPTH*4);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  wb_state_t             state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [ADDR_WIDTH-1:0] adr_nxt;
  logic                  req;
  logic                  adr_match;
  logic                  wr_en;
  logic                  ram_en;
  logic [IW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    adr_d     = adr_q;
    req       = wb.cyc & wb.stb;
    adr_match = (wb.adr[ADDR_WIDTH-1:2] == adr_q[ADDR_WIDTH-1:2]);
    adr_nxt   = ADDR_WIDTH'(next_burst_adr(32'(adr_q), wb.bte));

    case (state_q)
      IDLE: begin
        // ack/err high means the master is still holding the request being
        // terminated; it must not be taken as a new access.
        if (req && !ack_q && !err_q) begin
          adr_d = wb.adr;
          if (in_window(wb.adr)) begin
            ack_d = 1'b1;
            if (wb.cti == CTI_INCR) state_d = BURST;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BURST: begin
        // Every BURST cycle carries ack for adr_q; continue speculatively only
        // while the master confirms the predicted address with cti=incr.
        state_d = IDLE;
        case (wb.cti)
          CTI_INCR: begin
            if (req && adr_match) begin
              adr_d = adr_nxt;
              if (in_window(adr_nxt)) begin
                ack_d   = 1'b1;
                state_d = BURST;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          CTI_CLASSIC, CTI_EOB: ;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Single port: a write of the acked beat takes priority over fetching the
  // next beat; that fetch only matters for reads, so write bursts lose nothing.
  always_comb begin
    wr_en    = rst_ni & ack_q & req & wb.we;
    ram_en   = wr_en | (rst_ni & ack_d);
    ram_addr = wr_en ? adr_q[IW+1:2] : adr_d[IW+1:2];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
    end
  end

  pu_or1k_wb_sram_slave_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (wr_en),
    .be_i    (wb.sel),
    .addr_i  (ram_addr),
    .wdata_i (wb.dat_wr),
    .rdata_o (ram_rdata)
  );

  assign wb.dat_rd = ack_q ? ram_rdata : '0;
  assign wb.ack    = ack_q;
  assign wb.err    = err_q;
  assign wb.rty    = 1'b0;
endmodule

// File: tb/tb_pu_or1k_wb_sram_slave.sv
// Directed bench for pu_or1k_wb_sram_slave: classic-cycle vector table plus
// hand-written burst, abort, window-overflow and reset sequences.
module tb_pu_or1k_wb_sram_slave;
  logic clk;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  logic [31:0] shadow [logic [31:0]];

  pu_or1k_wb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  pu_or1k_wb_sram_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (1024),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .wb     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((bus.ack === 1'b1 && bus.err === 1'b1) || bus.rty !== 1'b0) begin
        errors++;
        $display("FAIL bus_monitor at %0t: got ack=%b err=%b rty=%b expected no ack&err and rty=0",
                 $time, bus.ack, bus.err, bus.rty);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.cti = 3'b000; bus.bte = 2'b00; bus.sel = 4'hF;
  endtask

  task automatic shadow_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = shadow.exists(a & ~32'h3) ? shadow[a & ~32'h3] : 32'h0;
    for (int unsigned b = 0; b < 4; b++)
      if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    shadow[a & ~32'h3] = w;
  endtask

  task automatic classic(input string nm, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic ea, input logic ee, input logic [31:0] ed);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = a;
    bus.dat_wr = d; bus.sel = s; bus.cti = 3'b000; bus.bte = 2'b00;
    chk({nm, " wait_ack"}, {31'b0, bus.ack}, 32'd0);
    tick;
    chk({nm, " ack"}, {31'b0, bus.ack}, {31'b0, ea});
    chk({nm, " err"}, {31'b0, bus.err}, {31'b0, ee});
    if (ea && !we) chk({nm, " rdat"}, bus.dat_rd, ed);
    if (ea && we) shadow_write(a, d, s);
    tick;
    idle_bus();
    chk({nm, " term_pulse"}, {30'b0, bus.ack, bus.err}, 32'd0);
  endtask

  task automatic burst_rd(input string nm, input logic [1:0] bte, input int unsigned n,
                          input logic [31:0] adrs [4]);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
    bus.bte = bte; bus.adr = adrs[0];
    bus.cti = (n == 1) ? 3'b111 : 3'b010;
    for (int unsigned k = 0; k < n; k++) begin
      tick;
      chk($sformatf("%s beat%0d ack", nm, k), {31'b0, bus.ack}, 32'd1);
      chk($sformatf("%s beat%0d rdat", nm, k), bus.dat_rd, shadow[adrs[k]]);
      bus.adr = adrs[k];
      bus.cti = (k == n - 1) ? 3'b111 : 3'b010;
    end
    tick;
    chk({nm, " end_ack"}, {31'b0, bus.ack}, 32'd0);
    idle_bus();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_AAEF});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_AAEF});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         4'hF, 1'b1, 1'b0, 32'hA5A5_A5A5});
    vecs.push_back('{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 32'h1122_3344});
    vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h89AB_CDEF, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'h8, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b1, 1'b0, 32'h01AB_CDEF});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0});

    rst_ni = 1'b0;
    bus.adr = '0; bus.dat_wr = '0;
    idle_bus();
    tick; tick;
    chk("reset ack", {31'b0, bus.ack}, 32'd0);
    chk("reset err", {31'b0, bus.err}, 32'd0);
    chk("reset dat", bus.dat_rd, 32'd0);
    rst_ni = 1'b1;
    tick;
    mon_en = 1'b1;

    foreach (vecs[i])
      classic($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat,
              vecs[i].sel, vecs[i].ack, vecs[i].err, vecs[i].rdat);

    // Fill the burst area with address-tagged words.
    for (int unsigned a = 0; a < 32'h40; a += 4)
      classic($sformatf("fill%02h", a), 1'b1, a, 32'hC0DE_0000 | a, 4'hF, 1'b1, 1'b0, 32'h0);
    classic("fillFF8", 1'b1, 32'hFF8, 32'hC0DE_0FF8, 4'hF, 1'b1, 1'b0, 32'h0);

    burst_rd("wrap4_38", 2'b01, 4, '{32'h38, 32'h3C, 32'h30, 32'h34});
    burst_rd("wrap4_34", 2'b01, 4, '{32'h34, 32'h38, 32'h3C, 32'h30});
    burst_rd("wrap8_38", 2'b10, 3, '{32'h38, 32'h3C, 32'h20, 32'h0});
    burst_rd("wrap16_3C", 2'b11, 2, '{32'h3C, 32'h00, 32'h0, 32'h0});

    // Linear write burst 0x40/0x44, then read it back as a burst.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.sel = 4'hF; bus.bte = 2'b00;
    bus.adr = 32'h40; bus.dat_wr = 32'h4040_4040; bus.cti = 3'b010;
    tick;
    chk("wrburst beat0 ack", {31'b0, bus.ack}, 32'd1);
    tick;
    chk("wrburst beat1 ack", {31'b0, bus.ack}, 32'd1);
    bus.adr = 32'h44; bus.dat_wr = 32'h4444_4444; bus.cti = 3'b111;
    tick;
    chk("wrburst end_ack", {31'b0, bus.ack}, 32'd0);
    idle_bus();
    shadow_write(32'h40, 32'h4040_4040, 4'hF);
    shadow_write(32'h44, 32'h4444_4444, 4'hF);
    burst_rd("rdburst_40", 2'b00, 2, '{32'h40, 32'h44, 32'h0, 32'h0});

    // Linear burst, stb dropped for two cycles after beat 2, resume at 0x08.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.bte = 2'b00;
    bus.adr = 32'h00; bus.cti = 3'b010;
    tick;
    chk("pause beat0 ack", {31'b0, bus.ack}, 32'd1);
    chk("pause beat0 rdat", bus.dat_rd, shadow[32'h00]);
    tick;
    chk("pause beat1 ack", {31'b0, bus.ack}, 32'd1);
    chk("pause beat1 rdat", bus.dat_rd, shadow[32'h04]);
    bus.adr = 32'h04;
    tick;
    bus.stb = 1'b0;
    tick;
    chk("pause ack_fall", {31'b0, bus.ack}, 32'd0);
    tick;
    bus.stb = 1'b1; bus.adr = 32'h08; bus.cti = 3'b010;
    chk("resume wait_ack", {31'b0, bus.ack}, 32'd0);
    tick;
    chk("resume beat0 ack", {31'b0, bus.ack}, 32'd1);
    chk("resume beat0 rdat", bus.dat_rd, shadow[32'h08]);
    tick;
    chk("resume beat1 ack", {31'b0, bus.ack}, 32'd1);
    chk("resume beat1 rdat", bus.dat_rd, shadow[32'h0C]);
    bus.adr = 32'h0C; bus.cti = 3'b111;
    tick;
    chk("resume end_ack", {31'b0, bus.ack}, 32'd0);
    idle_bus();
    tick;

    // Linear burst running off the window end: third beat terminates with err.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.bte = 2'b00;
    bus.adr = 32'hFF8; bus.cti = 3'b010;
    tick;
    chk("ovf beat0 rdat", bus.dat_rd, shadow[32'hFF8]);
    tick;
    chk("ovf beat1 ack", {31'b0, bus.ack}, 32'd1);
    chk("ovf beat1 rdat", bus.dat_rd, shadow[32'hFFC]);
    bus.adr = 32'hFFC;
    tick;
    chk("ovf beat2 err", {31'b0, bus.err}, 32'd1);
    chk("ovf beat2 ack", {31'b0, bus.ack}, 32'd0);
    idle_bus();
    tick;
    chk("ovf err_pulse", {31'b0, bus.err}, 32'd0);

    // Reset during the third beat of a burst; request held through the reset edge.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.bte = 2'b00;
    bus.adr = 32'h20; bus.cti = 3'b010;
    tick;
    tick;
    bus.adr = 32'h24;
    tick;
    chk("rst beat2 ack", {31'b0, bus.ack}, 32'd1);
    chk("rst beat2 rdat", bus.dat_rd, shadow[32'h28]);
    bus.adr = 32'h28;
    rst_ni = 1'b0;
    tick;
    chk("rst ack", {31'b0, bus.ack}, 32'd0);
    chk("rst err", {31'b0, bus.err}, 32'd0);
    rst_ni = 1'b1;
    idle_bus();
    tick;
    classic("post_rst_read", 1'b0, 32'h2C, 32'h0, 4'hF, 1'b1, 1'b0, shadow[32'h2C]);
    classic("post_rst_mem28", 1'b0, 32'h28, 32'h0, 4'hF, 1'b1, 1'b0, 32'hC0DE_0028);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
